// File: rtl/code_lock_ctrl.sv
// Sequencing controller for the Code_Detector: turns button levels into gated
// one-cycle pulses, judges each attempt from U, and runs the unlock/lockout timers.
module code_lock_ctrl #(
  parameter int PRESS_COUNT    = 4,
  parameter int MAX_FAIL       = 3,
  parameter int ENTRY_TIMEOUT  = 32,
  parameter int UNLOCK_CYCLES  = 16,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int CHECK_WIN      = 3
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            BtnStart,
  input  logic                            BtnRed,
  input  logic                            BtnGreen,
  input  logic                            BtnBlue,
  input  logic                            U,
  output logic                            Start,
  output logic                            Red,
  output logic                            Green,
  output logic                            Blue,
  output logic                            Det_Rst,
  output logic                            Unlock,
  output logic                            Locked_Out,
  output logic [$clog2(MAX_FAIL+1)-1:0]   Fail_Count,
  output logic                            Busy
);

  localparam int FC_W    = $clog2(MAX_FAIL + 1);
  localparam int PC_W    = $clog2(PRESS_COUNT + 1);
  localparam int T1      = (ENTRY_TIMEOUT > UNLOCK_CYCLES) ? ENTRY_TIMEOUT : UNLOCK_CYCLES;
  localparam int T2      = (T1 > LOCKOUT_CYCLES) ? T1 : LOCKOUT_CYCLES;
  localparam int TMR_MAX = (T2 > CHECK_WIN) ? T2 : CHECK_WIN;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ENTRY    = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_UNLOCKED = 3'd3;
  localparam logic [2:0] S_LOCKOUT  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PC_W-1:0]  press_q, press_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [FC_W-1:0]  fail_q, fail_d, fail_inc;
  logic             clr_q, clr_d;
  logic [3:0]       prev_q, btn, edg, pulse_q, pulse_d;
  logic             fail_evt, legal;

  // Button bit order throughout: {Start, Red, Green, Blue}
  assign btn      = {BtnStart, BtnRed, BtnGreen, BtnBlue};
  assign edg      = btn & ~prev_q;
  assign fail_inc = (fail_q == FC_W'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    press_d  = press_q;
    tmr_d    = tmr_q;
    fail_d   = fail_q;
    clr_d    = 1'b0;
    pulse_d  = 4'b0;
    fail_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        pulse_d = {edg[3], 3'b0};
        if (edg[3]) begin
          state_d = S_ENTRY;
          press_d = '0;
          tmr_d   = '0;
        end
      end
      S_ENTRY: begin
        pulse_d = {1'b0, edg[2:0]};
        // Simultaneous colour edges count as a single press.
        if (|edg[2:0]) begin
          tmr_d = '0;
          if (press_q == PC_W'(PRESS_COUNT - 1)) begin
            state_d = S_CHECK;
            press_d = '0;
          end else begin
            press_d = press_q + 1'b1;
          end
        end else if (tmr_q == TMR_W'(ENTRY_TIMEOUT - 1)) begin
          fail_evt = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (U) begin
          state_d = S_UNLOCKED;
          fail_d  = '0;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(CHECK_WIN - 1)) begin
          fail_evt = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_UNLOCKED: begin
        if (tmr_q == TMR_W'(UNLOCK_CYCLES - 1)) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (tmr_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          fail_d  = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        press_d = '0;
        tmr_d   = '0;
        fail_d  = '0;
      end
    endcase
    // A failed attempt always clears the detector before the next one.
    if (fail_evt) begin
      fail_d  = fail_inc;
      clr_d   = 1'b1;
      press_d = '0;
      tmr_d   = '0;
      state_d = (fail_inc == FC_W'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
    end
  end

  // Previous levels track every cycle so a held button can never edge late.
  always_ff @(posedge Clk) begin
    prev_q <= btn;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      press_q <= '0;
      tmr_q   <= '0;
      fail_q  <= '0;
      clr_q   <= 1'b0;
      pulse_q <= 4'b0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      tmr_q   <= tmr_d;
      fail_q  <= fail_d;
      clr_q   <= clr_d;
      pulse_q <= pulse_d;
    end
  end

  assign legal                    = (state_q <= S_LOCKOUT);
  assign {Start, Red, Green, Blue} = legal ? pulse_q : 4'b0;
  assign Fail_Count               = legal ? fail_q : '0;
  assign Unlock                   = (state_q == S_UNLOCKED);
  assign Locked_Out               = (state_q == S_LOCKOUT);
  assign Busy                     = (state_q == S_ENTRY) || (state_q == S_CHECK);
  assign Det_Rst                  = Rst | clr_q;

endmodule
